// File: rtl/freq_div_prog.sv
// Synchronous programmable divider: one-cycle tick every N enabled cycles plus a 2N square wave.
// Divisor reloads go through a shadow register and apply only at a wrap, or right away while disabled.
module freq_div_prog #(
  parameter int WIDTH       = 20,
  parameter int DEFAULT_DIV = 262144
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] div_in_i,
  input  logic             div_load_i,
  output logic             tick_o,
  output logic             clk_out_o,
  output logic             pend_o,
  output logic             err_o,
  output logic             done_o,
  output logic [WIDTH-1:0] cnt_o
);

  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_reg_q, div_reg_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             tick_q, tick_d;
  logic             clk_out_q, clk_out_d;
  logic             pend_q, pend_d;
  logic             err_q, err_d;
  logic             done_q, done_d;

  logic load_ok;
  logic load_bad;
  logic terminal;
  logic apply_ok;

  assign load_ok  = div_load_i && (div_in_i != '0);
  assign load_bad = div_load_i && (div_in_i == '0);
  // div_reg is never zero, so the subtraction cannot wrap; >= also catches an out-of-range count.
  assign terminal = (cnt_q >= (div_reg_q - WIDTH'(1)));
  // A load in the same cycle wins over applying the older shadow value.
  assign apply_ok = pend_q && !load_ok;

  always_comb begin
    cnt_d     = cnt_q;
    div_reg_d = div_reg_q;
    shadow_d  = shadow_q;
    tick_d    = 1'b0;
    clk_out_d = clk_out_q;
    pend_d    = pend_q;
    err_d     = load_bad;
    done_d    = done_q;

    if (load_ok) begin
      shadow_d = div_in_i;
      pend_d   = 1'b1;
    end

    if (clr_i) begin
      cnt_d     = '0;
      clk_out_d = 1'b0;
      done_d    = 1'b0;
    end else if (!en_i) begin
      if (apply_ok) begin
        div_reg_d = shadow_q;
        cnt_d     = '0;
        pend_d    = 1'b0;
      end
    end else if (!done_q) begin
      if (terminal) begin
        cnt_d     = '0;
        tick_d    = 1'b1;
        clk_out_d = ~clk_out_q;
        if (mode_i) begin
          done_d = 1'b1;
        end
        if (apply_ok) begin
          div_reg_d = shadow_q;
          pend_d    = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      div_reg_q <= DEF_DIV;
      shadow_q  <= DEF_DIV;
      tick_q    <= 1'b0;
      clk_out_q <= 1'b0;
      pend_q    <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_reg_q <= div_reg_d;
      shadow_q  <= shadow_d;
      tick_q    <= tick_d;
      clk_out_q <= clk_out_d;
      pend_q    <= pend_d;
      err_q     <= err_d;
      done_q    <= done_d;
    end
  end

  assign tick_o    = tick_q;
  assign clk_out_o = clk_out_q;
  assign pend_o    = pend_q;
  assign err_o     = err_q;
  assign done_o    = done_q;
  assign cnt_o     = cnt_q;

endmodule

// File: tb/tb_freq_div_prog.sv
// Bench for freq_div_prog: expected tick positions are queued as stimulus is applied and matched
// against ticks collected from the DUT; other outputs are checked against hand-derived constants.
module tb_freq_div_prog;

  localparam int W   = 20;
  localparam int DEF = 12;

  logic         clk = 1'b0;
  logic         rst, en, clr, mode, div_load;
  logic [W-1:0] div_in;
  logic         tick_o, clk_out_o, pend_o, err_o, done_o;
  logic [W-1:0] cnt_o;

  int checks   = 0;
  int failures = 0;

  int   exp_q[$];
  int   got_q[$];
  logic clk_hist[$];
  logic pend_hist[$];
  logic done_hist[$];
  int   e, g;

  freq_div_prog #(.WIDTH(W), .DEFAULT_DIV(DEF)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr), .mode_i(mode),
    .div_in_i(div_in), .div_load_i(div_load),
    .tick_o(tick_o), .clk_out_o(clk_out_o), .pend_o(pend_o),
    .err_o(err_o), .done_o(done_o), .cnt_o(cnt_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Runs n edges, recording which edge (1-based) produced a tick and the per-edge output history.
  task automatic collect(input int n);
    got_q.delete(); clk_hist.delete(); pend_hist.delete(); done_hist.delete();
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      #1;
      if (tick_o === 1'b1) got_q.push_back(i);
      clk_hist.push_back(clk_out_o);
      pend_hist.push_back(pend_o);
      done_hist.push_back(done_o);
    end
  endtask

  task automatic test_reset();
    rst = 1; en = 0; clr = 0; mode = 0; div_load = 0; div_in = '0;
    step(2);
    checks++; if (cnt_o !== '0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", cnt_o); end
    checks++; if (tick_o !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", tick_o); end
    checks++; if (clk_out_o !== 1'b0) begin failures++; $display("FAIL reset_clk_out got=%b exp=0", clk_out_o); end
    checks++; if (pend_o !== 1'b0) begin failures++; $display("FAIL reset_pend got=%b exp=0", pend_o); end
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_o); end
    checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done_o); end
    rst = 0; en = 1;
    exp_q.push_back(DEF); exp_q.push_back(2 * DEF);
    collect(30);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : -1;
      checks++; if (g !== e) begin failures++; $display("FAIL default_tick got=%0d exp=%0d", g, e); end
    end
    checks++; if (got_q.size() != 0) begin failures++; $display("FAIL default_extra_ticks got=%0d exp=0", got_q.size()); end
    checks++; if (clk_hist[DEF-1] !== 1'b1) begin failures++; $display("FAIL default_clk_rise got=%b exp=1", clk_hist[DEF-1]); end
    checks++; if (clk_hist[2*DEF-2] !== 1'b1) begin failures++; $display("FAIL default_clk_high got=%b exp=1", clk_hist[2*DEF-2]); end
    checks++; if (clk_hist[2*DEF-1] !== 1'b0) begin failures++; $display("FAIL default_clk_fall got=%b exp=0", clk_hist[2*DEF-1]); end
    checks++; if (cnt_o !== W'(6)) begin failures++; $display("FAIL default_cnt got=%0d exp=6", cnt_o); end
  endtask

  task automatic test_small_div();
    en = 0; div_in = W'(5); div_load = 1;
    step(1);
    checks++; if (pend_o !== 1'b1) begin failures++; $display("FAIL small_pend_set got=%b exp=1", pend_o); end
    div_load = 0;
    step(1);
    checks++; if (pend_o !== 1'b0) begin failures++; $display("FAIL small_pend_apply got=%b exp=0", pend_o); end
    checks++; if (cnt_o !== '0) begin failures++; $display("FAIL small_cnt_apply got=%0d exp=0", cnt_o); end
    en = 1;
    for (int k = 1; k <= 4; k++) exp_q.push_back(5 * k);
    collect(20);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : -1;
      checks++; if (g !== e) begin failures++; $display("FAIL small_tick got=%0d exp=%0d", g, e); end
    end
    checks++; if (got_q.size() != 0) begin failures++; $display("FAIL small_extra_ticks got=%0d exp=0", got_q.size()); end
    checks++; if (clk_hist[4] !== 1'b1) begin failures++; $display("FAIL small_clk_5 got=%b exp=1", clk_hist[4]); end
    checks++; if (clk_hist[9] !== 1'b0) begin failures++; $display("FAIL small_clk_10 got=%b exp=0", clk_hist[9]); end
    checks++; if (clk_hist[14] !== 1'b1) begin failures++; $display("FAIL small_clk_15 got=%b exp=1", clk_hist[14]); end
    step(2);
    en = 0;
    step(3);
    checks++; if (cnt_o !== W'(2)) begin failures++; $display("FAIL small_hold_cnt got=%0d exp=2", cnt_o); end
    checks++; if (tick_o !== 1'b0) begin failures++; $display("FAIL small_hold_tick got=%b exp=0", tick_o); end
    en = 1;
    exp_q.push_back(3);
    collect(3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : -1;
      checks++; if (g !== e) begin failures++; $display("FAIL gap_tick got=%0d exp=%0d", g, e); end
    end
    checks++; if (clk_out_o !== 1'b1) begin failures++; $display("FAIL gap_clk_out got=%b exp=1", clk_out_o); end
  endtask

  task automatic test_reload();
    step(2);
    div_in = W'(3); div_load = 1;
    step(1);
    div_load = 0;
    checks++; if (cnt_o !== W'(3)) begin failures++; $display("FAIL reload_cnt got=%0d exp=3", cnt_o); end
    checks++; if (pend_o !== 1'b1) begin failures++; $display("FAIL reload_pend got=%b exp=1", pend_o); end
    exp_q.push_back(2); exp_q.push_back(5); exp_q.push_back(8); exp_q.push_back(11);
    collect(11);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : -1;
      checks++; if (g !== e) begin failures++; $display("FAIL reload_tick got=%0d exp=%0d", g, e); end
    end
    checks++; if (got_q.size() != 0) begin failures++; $display("FAIL reload_extra_ticks got=%0d exp=0", got_q.size()); end
    checks++; if (pend_hist[0] !== 1'b1) begin failures++; $display("FAIL reload_pend_hold got=%b exp=1", pend_hist[0]); end
    checks++; if (pend_hist[1] !== 1'b0) begin failures++; $display("FAIL reload_pend_fall got=%b exp=0", pend_hist[1]); end
    step(2);
    div_in = W'(4); div_load = 1;
    step(1);
    div_load = 0;
    checks++; if (tick_o !== 1'b1) begin failures++; $display("FAIL coincide_tick got=%b exp=1", tick_o); end
    checks++; if (pend_o !== 1'b1) begin failures++; $display("FAIL coincide_pend got=%b exp=1", pend_o); end
    exp_q.push_back(3); exp_q.push_back(7);
    collect(8);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : -1;
      checks++; if (g !== e) begin failures++; $display("FAIL coincide_tick_pos got=%0d exp=%0d", g, e); end
    end
    checks++; if (got_q.size() != 0) begin failures++; $display("FAIL coincide_extra_ticks got=%0d exp=0", got_q.size()); end
    checks++; if (pend_hist[2] !== 1'b0) begin failures++; $display("FAIL coincide_pend_fall got=%b exp=0", pend_hist[2]); end
  endtask

  task automatic test_invalid_n1();
    div_in = '0; div_load = 1;
    step(1);
    div_load = 0;
    checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL invalid_err got=%b exp=1", err_o); end
    checks++; if (pend_o !== 1'b0) begin failures++; $display("FAIL invalid_pend got=%b exp=0", pend_o); end
    checks++; if (cnt_o !== W'(2)) begin failures++; $display("FAIL invalid_cnt got=%0d exp=2", cnt_o); end
    step(1);
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL invalid_err_pulse got=%b exp=0", err_o); end
    step(1);
    checks++; if (tick_o !== 1'b1) begin failures++; $display("FAIL invalid_div_kept got=%b exp=1", tick_o); end
    div_in = W'(1); div_load = 1;
    step(1);
    div_load = 0;
    for (int k = 3; k <= 8; k++) exp_q.push_back(k);
    collect(8);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : -1;
      checks++; if (g !== e) begin failures++; $display("FAIL n1_tick got=%0d exp=%0d", g, e); end
    end
    checks++; if (got_q.size() != 0) begin failures++; $display("FAIL n1_extra_ticks got=%0d exp=0", got_q.size()); end
    for (int k = 3; k <= 8; k++) begin
      checks++;
      if (clk_hist[k-1] !== ((k % 2 == 0) ? 1'b1 : 1'b0)) begin
        failures++; $display("FAIL n1_clk_out edge=%0d got=%b exp=%b", k, clk_hist[k-1], (k % 2 == 0));
      end
    end
    checks++; if (cnt_o !== '0) begin failures++; $display("FAIL n1_cnt got=%0d exp=0", cnt_o); end
  endtask

  task automatic test_oneshot();
    en = 0; div_in = W'(4); div_load = 1;
    step(1);
    div_load = 0;
    step(1);
    clr = 1;
    step(1);
    clr = 0; mode = 1; en = 1;
    exp_q.push_back(4);
    collect(24);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : -1;
      checks++; if (g !== e) begin failures++; $display("FAIL oneshot_tick got=%0d exp=%0d", g, e); end
    end
    checks++; if (got_q.size() != 0) begin failures++; $display("FAIL oneshot_extra_ticks got=%0d exp=0", got_q.size()); end
    checks++; if (done_hist[2] !== 1'b0) begin failures++; $display("FAIL oneshot_done_early got=%b exp=0", done_hist[2]); end
    checks++; if (done_hist[3] !== 1'b1) begin failures++; $display("FAIL oneshot_done_set got=%b exp=1", done_hist[3]); end
    checks++; if (clk_hist[23] !== 1'b1) begin failures++; $display("FAIL oneshot_clk_hold got=%b exp=1", clk_hist[23]); end
    checks++; if (cnt_o !== '0) begin failures++; $display("FAIL oneshot_cnt got=%0d exp=0", cnt_o); end
    mode = 0;
    step(1);
    checks++; if (done_o !== 1'b1) begin failures++; $display("FAIL oneshot_mode_change got=%b exp=1", done_o); end
    mode = 1; clr = 1;
    step(1);
    clr = 0;
    checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL oneshot_clr_done got=%b exp=0", done_o); end
    checks++; if (clk_out_o !== 1'b0) begin failures++; $display("FAIL oneshot_clr_clk got=%b exp=0", clk_out_o); end
    exp_q.push_back(4);
    collect(6);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : -1;
      checks++; if (g !== e) begin failures++; $display("FAIL oneshot_rearm_tick got=%0d exp=%0d", g, e); end
    end
    checks++; if (got_q.size() != 0) begin failures++; $display("FAIL oneshot_rearm_extra got=%0d exp=0", got_q.size()); end
  endtask

  task automatic test_clear_reset();
    mode = 0; en = 0; div_in = W'(8); div_load = 1;
    step(1);
    div_load = 0;
    step(1);
    clr = 1;
    step(1);
    clr = 0; en = 1;
    exp_q.push_back(8);
    collect(14);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : -1;
      checks++; if (g !== e) begin failures++; $display("FAIL clear_pre_tick got=%0d exp=%0d", g, e); end
    end
    checks++; if (cnt_o !== W'(6)) begin failures++; $display("FAIL clear_pre_cnt got=%0d exp=6", cnt_o); end
    checks++; if (clk_out_o !== 1'b1) begin failures++; $display("FAIL clear_pre_clk got=%b exp=1", clk_out_o); end
    clr = 1;
    step(1);
    clr = 0;
    checks++; if (cnt_o !== '0) begin failures++; $display("FAIL clear_cnt got=%0d exp=0", cnt_o); end
    checks++; if (clk_out_o !== 1'b0) begin failures++; $display("FAIL clear_clk got=%b exp=0", clk_out_o); end
    exp_q.push_back(8);
    collect(8);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : -1;
      checks++; if (g !== e) begin failures++; $display("FAIL clear_div_kept got=%0d exp=%0d", g, e); end
    end
    step(3);
    div_in = W'(6); div_load = 1;
    step(1);
    div_load = 0;
    step(1);
    checks++; if (cnt_o !== W'(5)) begin failures++; $display("FAIL rst_pre_cnt got=%0d exp=5", cnt_o); end
    checks++; if (pend_o !== 1'b1) begin failures++; $display("FAIL rst_pre_pend got=%b exp=1", pend_o); end
    rst = 1;
    step(1);
    checks++; if (cnt_o !== '0) begin failures++; $display("FAIL rst_cnt got=%0d exp=0", cnt_o); end
    checks++; if (pend_o !== 1'b0) begin failures++; $display("FAIL rst_pend got=%b exp=0", pend_o); end
    checks++; if (clk_out_o !== 1'b0) begin failures++; $display("FAIL rst_clk got=%b exp=0", clk_out_o); end
    checks++; if (tick_o !== 1'b0) begin failures++; $display("FAIL rst_tick got=%b exp=0", tick_o); end
    rst = 0;
    exp_q.push_back(DEF);
    collect(DEF + 1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : -1;
      checks++; if (g !== e) begin failures++; $display("FAIL rst_default_div got=%0d exp=%0d", g, e); end
    end
    checks++; if (got_q.size() != 0) begin failures++; $display("FAIL rst_extra_ticks got=%0d exp=0", got_q.size()); end
  endtask

  initial begin
    test_reset();
    test_small_div();
    test_reload();
    test_invalid_n1();
    test_oneshot();
    test_clear_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
